ldpc_dvb_enc_obuf_ctrl: RTL

Multi-buffer (ping-pong by default) output-buffer controller for the LDPC DVB-S2 encoder. Sits between the encoder engine, which writes codewords into N output buffer banks, and the output sink, which drains them. It allocates the write bank and sequences banks to the sink in FIFO order. It keeps per-bank frame size and tag, and generates the full/empty handshakes on both sides.

---
 rtl/ldpc_dvb_enc_obuf_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/ldpc_dvb_enc_obuf_ctrl.sv
// rtl/ldpc_dvb_enc_obuf_ctrl.sv - N-bank output-buffer controller for the LDPC DVB-S2 encoder
// Optional sticky overflow/underflow flags: define LDPC_DVB_ENC_OBUF_CTRL_ERR_EN.
module ldpc_dvb_enc_obuf_ctrl #(
  parameter int pBNUM_W = 1,
  parameter int pTAG_W  = 8,
  parameter int pCOL_W  = 8
) (
  input  logic               iclk,
  input  logic               ireset_n,
  input  logic               iclkena,
  input  logic               iwfull,
  input  logic [pCOL_W-1:0]  iwsize,
  input  logic [pTAG_W-1:0]  iwtag,
  output logic               owfull,
  output logic [pBNUM_W-1:0] owsel,
  output logic               orfull,
  output logic [pCOL_W-1:0]  orsize,
  output logic [pTAG_W-1:0]  ortag,
  output logic [pBNUM_W-1:0] orsel,
  input  logic               irempty,
  output logic               ooverflow,
  output logic               ounderflow
);

  localparam int cN = 2 ** pBNUM_W;
  localparam logic [pBNUM_W:0] cCNT_FULL = (pBNUM_W+1)'(cN);

  logic [pBNUM_W-1:0] r_wptr;
  logic [pBNUM_W-1:0] r_rptr;
  logic [pBNUM_W:0]   r_cnt;
  logic [pCOL_W-1:0]  r_size [cN];
  logic [pTAG_W-1:0]  r_tag  [cN];

  logic w_owfull;
  logic w_orfull;
  logic w_accept;
  logic w_release;

  assign w_owfull  = (r_cnt == cCNT_FULL);
  assign w_orfull  = (r_cnt != '0);
  assign w_accept  = iwfull  & ~w_owfull;
  assign w_release = irempty &  w_orfull;

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < cN; i++) begin
        r_size[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (iclkena) begin
      if (w_accept) begin
        r_size[r_wptr] <= iwsize;
        r_tag[r_wptr]  <= iwtag;
        r_wptr         <= r_wptr + pBNUM_W'(1);
      end
      if (w_release) begin
        r_rptr <= r_rptr + pBNUM_W'(1);
      end
      // simultaneous accept and release leaves occupancy unchanged
      case ({w_accept, w_release})
        2'b10:   r_cnt <= r_cnt + (pBNUM_W+1)'(1);
        2'b01:   r_cnt <= r_cnt - (pBNUM_W+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef LDPC_DVB_ENC_OBUF_CTRL_ERR_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (iclkena) begin
      if (iwfull & w_owfull) r_ovf <= 1'b1;
      if (irempty & ~w_orfull) r_unf <= 1'b1;
    end
  end

  assign ooverflow  = r_ovf;
  assign ounderflow = r_unf;
`else
  assign ooverflow  = 1'b0;
  assign ounderflow = 1'b0;
`endif

  assign owfull = w_owfull;
  assign orfull = w_orfull;
  assign owsel  = r_wptr;
  assign orsel  = r_rptr;
  assign orsize = r_size[r_rptr];
  assign ortag  = r_tag[r_rptr];

endmodule
